// File: rtl/memory_read_responder_pkg.sv
// Shared types and helpers for the engine instruction-memory read responder.
package memory_read_responder_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ISSUE   = 2'd1,
      RESPOND = 2'd2
   } state_e;

   function automatic int line_addr_width(input int mem_addr_width, input int cache_block_width_bits);
      return mem_addr_width - cache_block_width_bits;
   endfunction

endpackage

// File: rtl/memory_read_responder_if.sv
// Engine read / host program-load bundle between the engine array and the memory responder.
interface memory_read_responder_if
#(
   parameter int MEMORY_WIDTH           = 20,
   parameter int MEMORY_ADDR_WIDTH      = 11,
   parameter int CACHE_BLOCK_WIDTH_BITS = 2,
   parameter int ENGINE_ID_BITS         = 2
);
   import memory_read_responder_pkg::*;

   localparam int N      = 2**ENGINE_ID_BITS;
   localparam int LA     = line_addr_width(MEMORY_ADDR_WIDTH, CACHE_BLOCK_WIDTH_BITS);
   localparam int LINE_W = MEMORY_WIDTH * (2**CACHE_BLOCK_WIDTH_BITS);

   logic                         wr_en;
   logic [MEMORY_ADDR_WIDTH-1:0] wr_addr;
   logic [MEMORY_WIDTH-1:0]      wr_data;
   logic [N-1:0]                 req_valid;
   logic [N*LA-1:0]              req_addr;
   logic [N-1:0]                 resp_ready;
   logic [LINE_W-1:0]            resp_data;
   logic [LA-1:0]                broadcast_addr;
   logic                         broadcast_valid;
   logic                         busy;

   modport master (
      output wr_en, wr_addr, wr_data, req_valid, req_addr,
      input  resp_ready, resp_data, broadcast_addr, broadcast_valid, busy
   );

   modport slave (
      input  wr_en, wr_addr, wr_data, req_valid, req_addr,
      output resp_ready, resp_data, broadcast_addr, broadcast_valid, busy
   );

endinterface

// File: rtl/memory_read_responder_rr_arbiter.sv
// Round-robin arbiter: first asserted request at or after ptr, wrapping N-1 -> 0.
module rr_arbiter
#(
   parameter int N     = 4,
   parameter int IDX_W = 2
)
(
   input  logic [N-1:0]     req,
   input  logic [IDX_W-1:0] ptr,
   output logic [N-1:0]     grant,
   output logic [IDX_W-1:0] grant_idx,
   output logic             grant_valid
);

   logic [IDX_W-1:0] cand;

   // N is a power of two, so the index adder wraps naturally
   always_comb begin
      grant       = '0;
      grant_idx   = '0;
      grant_valid = 1'b0;
      cand        = '0;
      for (int i = 0; i < N; i++) begin
         cand = ptr + IDX_W'(i);
         if (!grant_valid && req[cand]) begin
            grant_valid = 1'b1;
            grant_idx   = cand;
            grant[cand] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/memory_read_responder.sv
// Program memory with round-robin line reads for the engine array.
// Optional MEM_RESP_COALESCE_EN: engines waiting on the served line are acknowledged together.
module memory_read_responder
   import memory_read_responder_pkg::*;
#(
   parameter int MEMORY_WIDTH           = 20,
   parameter int MEMORY_ADDR_WIDTH      = 11,
   parameter int CACHE_BLOCK_WIDTH_BITS = 2,
   parameter int ENGINE_ID_BITS         = 2
)
(
   input  logic                    clk,
   input  logic                    rst,
   memory_read_responder_if.slave  bus
);

   // state   | meaning
   // IDLE    | waiting for a request; grant and line read start on exit
   // ISSUE   | memory output valid, captured into resp_data
   // RESPOND | line broadcast, resp_ready pulse, pointer rotates
   localparam int N      = 2**ENGINE_ID_BITS;
   localparam int LA     = line_addr_width(MEMORY_ADDR_WIDTH, CACHE_BLOCK_WIDTH_BITS);
   localparam int WPL    = 2**CACHE_BLOCK_WIDTH_BITS;
   localparam int LINE_W = MEMORY_WIDTH * WPL;

   localparam logic [1:0] ST_IDLE    = IDLE;
   localparam logic [1:0] ST_ISSUE   = ISSUE;
   localparam logic [1:0] ST_RESPOND = RESPOND;

   logic [1:0]                        state;
   logic [ENGINE_ID_BITS-1:0]         ptr;
   logic [ENGINE_ID_BITS-1:0]         grant_idx_q;
   logic [N-1:0]                      grant_oh_q;
   logic [LA-1:0]                     addr_q;
   logic [LA-1:0]                     bcast_addr_q;
   logic [LINE_W-1:0]                 resp_data_q;
   logic [LINE_W-1:0]                 mem_q;
   logic [N-1:0]                      resp_ready_c;

   logic [N-1:0]                      arb_oh;
   logic [ENGINE_ID_BITS-1:0]         arb_idx;
   logic                              arb_valid;
   logic [LA-1:0]                     arb_addr;

   logic [LA-1:0]                     wr_line;
   logic [CACHE_BLOCK_WIDTH_BITS-1:0] wr_slot;

   logic [LINE_W-1:0] mem [0:(2**LA)-1];

   rr_arbiter #(
      .N     (N),
      .IDX_W (ENGINE_ID_BITS)
   ) u_arb (
      .req         (bus.req_valid),
      .ptr         (ptr),
      .grant       (arb_oh),
      .grant_idx   (arb_idx),
      .grant_valid (arb_valid)
   );

   assign arb_addr = bus.req_addr[arb_idx*LA +: LA];
   assign wr_line  = bus.wr_addr[MEMORY_ADDR_WIDTH-1:CACHE_BLOCK_WIDTH_BITS];
   assign wr_slot  = bus.wr_addr[CACHE_BLOCK_WIDTH_BITS-1:0];

   // Line-wide BRAM with per-word enables; the registered read sees pre-write data.
   always_ff @(posedge clk) begin
      if (bus.wr_en) begin
         for (int w = 0; w < WPL; w++) begin
            if (wr_slot == CACHE_BLOCK_WIDTH_BITS'(w))
               mem[wr_line][w*MEMORY_WIDTH +: MEMORY_WIDTH] <= bus.wr_data;
         end
      end
      if (state == ST_IDLE && arb_valid)
         mem_q <= mem[arb_addr];
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state        <= ST_IDLE;
         ptr          <= '0;
         grant_idx_q  <= '0;
         grant_oh_q   <= '0;
         addr_q       <= '0;
         bcast_addr_q <= '0;
         resp_data_q  <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (arb_valid) begin
                  grant_idx_q <= arb_idx;
                  grant_oh_q  <= arb_oh;
                  addr_q      <= arb_addr;
                  state       <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               resp_data_q  <= mem_q;
               bcast_addr_q <= addr_q;
               state        <= ST_RESPOND;
            end
            ST_RESPOND: begin
               ptr   <= grant_idx_q + ENGINE_ID_BITS'(1);
               state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   always_comb begin
      resp_ready_c = '0;
      if (state == ST_RESPOND) begin
         resp_ready_c = grant_oh_q;
`ifdef MEM_RESP_COALESCE_EN
         for (int j = 0; j < N; j++) begin
            if (bus.req_valid[j] && bus.req_addr[j*LA +: LA] == addr_q)
               resp_ready_c[j] = 1'b1;
         end
`endif
      end
   end

   assign bus.resp_ready      = resp_ready_c;
   assign bus.resp_data       = resp_data_q;
   assign bus.broadcast_addr  = bcast_addr_q;
   assign bus.broadcast_valid = (state == ST_RESPOND);
   assign bus.busy            = (state != ST_IDLE);

endmodule

// File: tb/tb_memory_read_responder.sv
// Self-checking bench for memory_read_responder: vector table, corner sequences, random traffic vs. model.
module tb_memory_read_responder;

   localparam int MW  = 20;
   localparam int MAW = 11;
   localparam int CBB = 2;
   localparam int EIB = 2;
   localparam int N   = 4;
   localparam int LA  = 9;

   localparam logic [79:0] L0   = 80'h55555AAAAA00000FFFFF;
   localparam logic [79:0] L1   = 80'h10004100031000210001;
   localparam logic [79:0] L2   = 80'h02003020020200102000;
   localparam logic [79:0] L2N  = 80'h0200302002020010ABCD;
   localparam logic [79:0] L3   = 80'h03030333333030330003;
   localparam logic [79:0] L4   = 80'h40004400034000240001;
   localparam logic [79:0] L5   = 80'h44444333332222211111;
   localparam logic [79:0] L6   = 80'h60004600036000260001;
   localparam logic [79:0] L7   = 80'h70003700027000170000;
   localparam logic [79:0] L9   = 80'h99993999929999199990;
   localparam logic [79:0] L511 = 80'hFF003FF002FF001FF000;

   typedef struct {
      int          line;
      logic [79:0] data;
   } pre_t;

   typedef struct {
      string       name;
      logic [3:0]  rv;
      logic [35:0] ra;
      logic [3:0]  er;
      logic [8:0]  ea;
      logic [79:0] ed;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   memory_read_responder_if #(
      .MEMORY_WIDTH(MW), .MEMORY_ADDR_WIDTH(MAW),
      .CACHE_BLOCK_WIDTH_BITS(CBB), .ENGINE_ID_BITS(EIB)
   ) bus ();

   memory_read_responder #(
      .MEMORY_WIDTH(MW), .MEMORY_ADDR_WIDTH(MAW),
      .CACHE_BLOCK_WIDTH_BITS(CBB), .ENGINE_ID_BITS(EIB)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_cmp = 0;
   int n_err = 0;
   logic [MW-1:0] mem_m [0:2047];
   logic [8:0]    last_a;
   logic [79:0]   last_d;

   pre_t pre [11];
   vec_t vecs [6];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [79:0] line_of(input int l);
      return {mem_m[l*4+3], mem_m[l*4+2], mem_m[l*4+1], mem_m[l*4]};
   endfunction

   task automatic chk_out(input string name, input logic [3:0] r, input logic v, input logic b,
                          input logic [8:0] a, input logic [79:0] d);
      logic [94:0] act, exp;
      act = {bus.resp_ready, bus.broadcast_valid, bus.busy, bus.broadcast_addr, bus.resp_data};
      exp = {r, v, b, a, d};
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got rdy=%b bv=%b busy=%b addr=%0d data=%h, expected rdy=%b bv=%b busy=%b addr=%0d data=%h",
                  name, bus.resp_ready, bus.broadcast_valid, bus.busy, bus.broadcast_addr, bus.resp_data,
                  r, v, b, a, d);
      end
   endtask

   task automatic wr_word(input int addr, input logic [MW-1:0] d);
      bus.wr_en   = 1'b1;
      bus.wr_addr = addr[MAW-1:0];
      bus.wr_data = d;
      mem_m[addr] = d;
      tick();
      bus.wr_en   = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int          g, gidx, ga, ptr_m;
      logic [79:0] gd;
      logic [3:0]  served_prev, er;
      logic        ev, eb;
      int          eng_act [N];
      int          eng_line [N];

      pre[0]  = '{0, L0};    pre[1]  = '{1, L1};  pre[2] = '{2, L2};  pre[3] = '{3, L3};
      pre[4]  = '{4, L4};    pre[5]  = '{5, L5};  pre[6] = '{6, L6};  pre[7] = '{7, L7};
      pre[8]  = '{9, L9};    pre[9]  = '{511, L511};
      pre[10] = '{8, 80'h0};

      vecs[0] = '{"single_e2_line5", 4'b0100, {9'd7, 9'd5, 9'd7, 9'd7}, 4'b0100, 9'd5, L5};
      vecs[1] = '{"single_e0_line5", 4'b0001, {9'd5, 9'd5, 9'd5, 9'd5}, 4'b0001, 9'd5, L5};
      vecs[2] = '{"single_e3_line2", 4'b1000, {9'd2, 9'd0, 9'd0, 9'd0}, 4'b1000, 9'd2, L2};
      vecs[3] = '{"single_e1_line9", 4'b0010, {9'd0, 9'd0, 9'd9, 9'd0}, 4'b0010, 9'd9, L9};
      vecs[4] = '{"single_e0_line0", 4'b0001, {9'd0, 9'd0, 9'd0, 9'd0}, 4'b0001, 9'd0, L0};
      vecs[5] = '{"single_e3_line511", 4'b1000, {9'd511, 9'd0, 9'd0, 9'd0}, 4'b1000, 9'd511, L511};

      for (int i = 0; i < 2048; i++) mem_m[i] = '0;
      bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
      bus.req_valid = '0; bus.req_addr = '0;
      rst = 1'b0;
      tick();

      // program load while held in reset
      for (int p = 0; p < 11; p++)
         for (int w = 0; w < 4; w++)
            wr_word(pre[p].line*4 + w, pre[p].data[w*MW +: MW]);

      // reset with all engines requesting
      bus.req_valid = 4'b1111;
      bus.req_addr  = {9'd3, 9'd2, 9'd1, 9'd0};
      tick();
      chk_out("reset_hold_a", 4'b0, 1'b0, 1'b0, 9'd0, 80'h0);
      tick();
      chk_out("reset_hold_b", 4'b0, 1'b0, 1'b0, 9'd0, 80'h0);
      last_a = '0; last_d = '0;

      // fairness: continuous requests from everyone
      rst = 1'b1;
      for (int k = 0; k < 15; k++) begin
         logic [3:0] r;
         r = '0;
         if (k % 3 == 2) begin
            int e;
            e = ((k - 2) / 3) % 4;
            r = 4'(1) << e;
            last_a = 9'(e);
            last_d = line_of(e);
         end
         chk_out($sformatf("fair_k%0d", k), r, r != 0, (k % 3) != 0, last_a, last_d);
         if (k == 14) bus.req_valid = '0;
         tick();
      end

      // coalescing: engines 1 and 3 on line 7, pointer now at 1
      bus.req_addr  = {9'd7, 9'd0, 9'd7, 9'd0};
      bus.req_valid = 4'b1010;
      tick();
      tick();
`ifdef MEM_RESP_COALESCE_EN
      chk_out("coalesce_both", 4'b1010, 1'b1, 1'b1, 9'd7, L7);
      bus.req_valid = '0;
      tick(); tick(); tick();
      chk_out("coalesce_none_after", 4'b0000, 1'b0, 1'b0, 9'd7, L7);
`else
      chk_out("coalesce_first", 4'b0010, 1'b1, 1'b1, 9'd7, L7);
      bus.req_valid = 4'b1000;
      tick(); tick(); tick();
      chk_out("coalesce_second", 4'b1000, 1'b1, 1'b1, 9'd7, L7);
      bus.req_valid = '0;
`endif
      last_a = 9'd7; last_d = L7;
      tick();

      for (int v = 0; v < 6; v++) begin
         bus.req_addr  = vecs[v].ra;
         bus.req_valid = vecs[v].rv;
         tick();
         chk_out({vecs[v].name, "_issue"}, 4'b0, 1'b0, 1'b1, last_a, last_d);
         tick();
         chk_out(vecs[v].name, vecs[v].er, 1'b1, 1'b1, vecs[v].ea, vecs[v].ed);
         last_a = vecs[v].ea; last_d = vecs[v].ed;
         bus.req_valid = '0;
         tick();
      end

      // write/read collision on line 2 in the grant cycle
      bus.req_addr  = {9'd0, 9'd0, 9'd0, 9'd2};
      bus.req_valid = 4'b0001;
      bus.wr_en = 1'b1; bus.wr_addr = 11'd8; bus.wr_data = 20'h0ABCD;
      tick();
      mem_m[8] = 20'h0ABCD;
      bus.wr_en = 1'b0;
      tick();
      chk_out("collision_old_data", 4'b0001, 1'b1, 1'b1, 9'd2, L2);
      bus.req_valid = '0;
      tick();
      bus.req_valid = 4'b0001;
      tick(); tick();
      chk_out("collision_reread", 4'b0001, 1'b1, 1'b1, 9'd2, L2N);
      bus.req_valid = '0;
      tick();

      // reset while in ISSUE, request held throughout
      bus.req_addr  = {9'd0, 9'd0, 9'd5, 9'd0};
      bus.req_valid = 4'b0010;
      tick();
      chk_out("rstmid_issue", 4'b0, 1'b0, 1'b1, 9'd2, L2N);
      rst = 1'b0;
      tick();
      chk_out("rstmid_cleared", 4'b0, 1'b0, 1'b0, 9'd0, 80'h0);
      rst = 1'b1;
      tick();
      chk_out("rstmid_reissue", 4'b0, 1'b0, 1'b1, 9'd0, 80'h0);
      tick();
      chk_out("rstmid_reserved", 4'b0010, 1'b1, 1'b1, 9'd5, L5);
      bus.req_valid = '0;
      tick();

      // random traffic against the spec-level model, from a fresh reset
      rst = 1'b0;
      tick();
      rst = 1'b1;
      g = -100; gidx = 0; ga = 0; gd = '0; ptr_m = 0;
      last_a = '0; last_d = '0; served_prev = '0;
      for (int e = 0; e < N; e++) begin eng_act[e] = 0; eng_line[e] = 0; end
      for (int c = 0; c < 800; c++) begin
         logic          do_wr;
         int            waddr;
         logic [MW-1:0] wdata;
         for (int e = 0; e < N; e++) begin
            if (served_prev[e]) eng_act[e] = 0;
            if (eng_act[e] == 0 && $urandom_range(0, 3) == 0) begin
               eng_act[e]  = 1;
               eng_line[e] = $urandom_range(0, 7);
            end
            bus.req_valid[e]            = (eng_act[e] != 0);
            bus.req_addr[e*LA +: LA]    = 9'(eng_line[e]);
         end
         do_wr = ($urandom_range(0, 3) == 0);
         waddr = $urandom_range(0, 31);
         wdata = 20'($urandom);
         bus.wr_en = do_wr; bus.wr_addr = waddr[MAW-1:0]; bus.wr_data = wdata;

         er = '0; ev = 1'b0;
         if (c == g + 2) begin
            er = 4'(1) << gidx;
`ifdef MEM_RESP_COALESCE_EN
            for (int j = 0; j < N; j++)
               if (eng_act[j] != 0 && eng_line[j] == ga) er[j] = 1'b1;
`endif
            ev = 1'b1;
            last_a = 9'(ga);
            last_d = gd;
         end
         eb = (c == g + 1) || (c == g + 2);
         @(negedge clk);
         chk_out($sformatf("rand_c%0d", c), er, ev, eb, last_a, last_d);
         served_prev = er;

         if (c >= g + 3) begin
            for (int i = 0; i < N; i++) begin
               int e;
               e = (ptr_m + i) % N;
               if (c != g && eng_act[e] != 0) begin
                  g = c; gidx = e; ga = eng_line[e]; gd = line_of(ga);
                  ptr_m = (e + 1) % N;
               end
            end
         end
         if (do_wr) mem_m[waddr] = wdata;
         @(posedge clk);
         #1;
      end
      bus.req_valid = '0;
      bus.wr_en = 1'b0;
      tick(); tick(); tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/memory_read_responder.md
# memory_read_responder

Serves the instruction-memory read requests issued by the regex engines: the memory end of the engine read interface. Holds the program memory and arbitrates round-robin among 2**CC_ENGINE_BITS requesters. Returns one cache line per grant and broadcasts the served line address so that every engine can snoop it. Sits between the host program-load path and the engine array in the coprocessor.

## Interface
Parameters:
- MEMORY_WIDTH, 20, bits per memory word (one instruction)
- MEMORY_ADDR_WIDTH, 11, word address width; depth 2**MEMORY_ADDR_WIDTH words
- CACHE_BLOCK_WIDTH_BITS, 2, log2 of words per line; LINE_W = MEMORY_WIDTH*2**CACHE_BLOCK_WIDTH_BITS
- ENGINE_ID_BITS, 2, log2 of requester count N

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous reset, active-low (rst==0 resets on the clock edge)
- wr_en  in  1  host program-load write strobe
- wr_addr  in  MEMORY_ADDR_WIDTH  word address of the write
- wr_data  in  MEMORY_WIDTH  word to write
- req_valid  in  N  per-engine read request; held until its resp_ready
- req_addr  in  N*LA  per-engine line address, LA = MEMORY_ADDR_WIDTH-CACHE_BLOCK_WIDTH_BITS; engine i in slice [i*LA +: LA]
- resp_ready  out  N  one-cycle pulse: line for engine i is on resp_data
- resp_data  out  LINE_W  shared response line, word 0 in LSBs
- broadcast_addr  out  LA  line address being served
- broadcast_valid  out  1  resp_data/broadcast_addr valid this cycle
- busy  out  1  FSM not in IDLE

## Operation
- FSM states: IDLE, ISSUE, RESPOND.
- IDLE: if any req_valid, the rr_arbiter grants one index; latch grant and its req_addr; start BRAM line read; -> ISSUE. Otherwise stay.
- ISSUE: BRAM output becomes available; register into resp_data; -> RESPOND.
- RESPOND: drive broadcast_valid=1, broadcast_addr=latched address, resp_ready[grant]=1 for one cycle; rotate priority pointer to grant+1 (mod N); -> IDLE.
- Round-robin: search starts at pointer, wraps from N-1 to 0; pointer resets to 0.
- Engines must hold req_valid/req_addr stable until resp_ready; a request dropped before service is simply not served (no error).
- Write port: one word per cycle, any state. The word lands at line wr_addr[MSBs], word slot wr_addr[CACHE_BLOCK_WIDTH_BITS-1:0]. Per-word write enables are used, with no read-modify-write.
- Write/read collision to the same line in the IDLE->ISSUE cycle: read-first; the response carries old data and the write still completes.
- Reset mid-operation: state->IDLE, pending grant discarded, no resp_ready issued. Memory contents are retained (not cleared).

## Timing
- Request first seen in IDLE at cycle t -> resp_ready/broadcast_valid at t+2; next grant sampled at t+3. Peak throughput is 1 line / 3 cycles.
- Reset values: resp_ready=0, broadcast_valid=0, broadcast_addr=0, resp_data=0, busy=0.
- resp_data and broadcast_addr are registered and hold their value outside RESPOND. Only broadcast_valid qualifies them.
- Simultaneous requests from all N: served in pointer order, one per 3 cycles, with no starvation.

## Configuration
- MEM_RESP_COALESCE_EN defined: in RESPOND, every engine j with req_valid[j]=1 and req_addr slice j equal to the latched address also gets resp_ready[j]=1 in the same cycle. The pointer still advances from the granted index only.
- Not defined: only resp_ready[grant] pulses. Other engines must snoop broadcast_* themselves or re-request.

## Structure
- Package memory_read_responder_pkg: state enum (IDLE, ISSUE, RESPOND) and a line-address-width function (MEMORY_ADDR_WIDTH-CACHE_BLOCK_WIDTH_BITS).
- Sub-module rr_arbiter: N-bit request vector, pointer input, one-hot grant plus encoded index.
- Storage is an inferred simple dual-port BRAM with per-word write enables and read-first behaviour.

## Test plan
- Reset: hold rst=0 for 2 cycles with req_valid=4'b1111 -> all outputs 0, no resp_ready; release -> first grant to engine 0.
- Single request: load line 5 words {0x11111,0x22222,0x33333,0x44444}; engine 2 requests addr 5 at cycle t -> resp_ready=4'b0100 at t+2, resp_data=0x44444_33333_22222_11111, broadcast_addr=5.
- Fairness: all 4 engines request continuously -> grant order 0,1,2,3,0 at 3-cycle spacing, no engine served twice before the others.
- Coalescing: engines 1 and 3 both request addr 7. With MEM_RESP_COALESCE_EN -> resp_ready=4'b1010 in one cycle. Without -> 4'b0010, then 4'b1000 three cycles later.
- Collision: write 0x0ABCD to word 8 (line 2) in the same cycle that IDLE grants a read of line 2 -> response shows the old word; a re-read shows 0x0ABCD.
- Reset mid-operation: assert rst in ISSUE -> no resp_ready; after release, the same held request is re-served with correct data.
